// File: rtl/cfg_stream_pkg.sv
// Shared definitions for the configuration stream loader: opcodes, header field
// positions, FSM state encoding and config word width.
package cfg_stream_pkg;

    // Also the width of the switch-box config registers.
    localparam int unsigned CFG_WORD_W = 32;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_END   = 2'b10;

    localparam int unsigned OP_MSB     = 31;
    localparam int unsigned OP_LSB     = 30;
    localparam int unsigned PARITY_BIT = 29;
    localparam int unsigned ADDR_MSB   = 15;
    localparam int unsigned ADDR_LSB   = 0;
    localparam int unsigned ADDR_W     = ADDR_MSB - ADDR_LSB + 1;

    typedef enum logic [1:0] {
        StHeader,
        StData,
        StWrite,
        StDone
    } cfg_state_e;

endpackage

// File: rtl/cfg_addr_decoder.sv
// Combinational tile address decoder: one-hot select plus an in-range flag.
module cfg_addr_decoder
    import cfg_stream_pkg::*;
#(
    parameter int unsigned NUM_TILES = 16
) (
    input  logic [ADDR_W-1:0]    addr_i,
    output logic [NUM_TILES-1:0] onehot_o,
    output logic                 in_range_o
);

    assign in_range_o = (32'(addr_i) < NUM_TILES);

    always_comb begin
        onehot_o = '0;
        for (int unsigned i = 0; i < NUM_TILES; i++) begin
            onehot_o[i] = (32'(addr_i) == i);
        end
    end

endmodule

// File: rtl/cfg_stream_loader.sv
// Parses (header, data) word pairs into single-cycle one-hot tile write strobes.
// Optional header parity check enabled by defining CFG_STREAM_LOADER_PARITY_EN.
module cfg_stream_loader
    import cfg_stream_pkg::*;
#(
    parameter int unsigned NUM_TILES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_in_valid,
    output logic                  cfg_in_ready,
    input  logic [CFG_WORD_W-1:0] cfg_in_data,
    output logic [CFG_WORD_W-1:0] config_data,
    output logic [NUM_TILES-1:0]  config_en,
    output logic                  config_done,
    output logic                  config_error,
    output logic [15:0]           write_count
);

    cfg_state_e            state_q, state_d;
    logic                  ready_q, ready_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [CFG_WORD_W-1:0] data_q, data_d;
    logic [NUM_TILES-1:0]  en_q, en_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  xfer;
    logic [1:0]            opcode;
    logic [NUM_TILES-1:0]  dec_onehot;
    logic                  dec_in_range;
    logic                  parity_ok;

    assign xfer   = cfg_in_valid && ready_q;
    assign opcode = cfg_in_data[OP_MSB:OP_LSB];

    cfg_addr_decoder #(
        .NUM_TILES (NUM_TILES)
    ) u_addr_decoder (
        .addr_i     (addr_q),
        .onehot_o   (dec_onehot),
        .in_range_o (dec_in_range)
    );

`ifdef CFG_STREAM_LOADER_PARITY_EN
    logic par_q, par_d;

    // Header parity must match the XOR of the data word it precedes.
    assign parity_ok = (par_q == ^cfg_in_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    always_comb begin
        par_d = par_q;
        if (state_q == StHeader && xfer && opcode == OP_WRITE) begin
            par_d = cfg_in_data[PARITY_BIT];
        end
    end
`else
    assign parity_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StHeader;
            ready_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHeader: begin
                if (xfer && opcode == OP_WRITE) begin
                    state_d = StData;
                end else if (xfer && opcode == OP_END) begin
                    state_d = StDone;
                end
            end
            StData: begin
                if (xfer) begin
                    state_d = StWrite;
                end
            end
            StWrite: state_d = StHeader;
            StDone:  state_d = StDone;
            default: state_d = StHeader;
        endcase
    end

    always_comb begin
        ready_d = (state_d == StHeader) || (state_d == StData);
        addr_d  = addr_q;
        data_d  = data_q;
        en_d    = '0;
        done_d  = done_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StHeader: begin
                if (xfer) begin
                    if (opcode == OP_WRITE) begin
                        addr_d = cfg_in_data[ADDR_MSB:ADDR_LSB];
                    end else if (opcode == OP_END) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    data_d = cfg_in_data;
                    if (dec_in_range && parity_ok) begin
                        en_d = dec_onehot;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StWrite: begin
                if (|en_q && cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: ;
        endcase
    end

    assign cfg_in_ready = ready_q;
    assign config_data  = data_q;
    assign config_en    = en_q;
    assign config_done  = done_q;
    assign config_error = err_q;
    assign write_count  = cnt_q;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader: directed scenarios plus random stream
// compared every cycle against a word-level model of the loader protocol.
module tb_cfg_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_in_valid;
    logic        cfg_in_ready;
    logic [31:0] cfg_in_data;
    logic [31:0] config_data;
    logic [15:0] config_en;
    logic        config_done;
    logic        config_error;
    logic [15:0] write_count;

    int vectors = 0;
    int miscompares = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    cfg_stream_loader #(
        .NUM_TILES (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_in_valid (cfg_in_valid),
        .cfg_in_ready (cfg_in_ready),
        .cfg_in_data  (cfg_in_data),
        .config_data  (config_data),
        .config_en    (config_en),
        .config_done  (config_done),
        .config_error (config_error),
        .write_count  (write_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a header arms a pending write, the next accepted word
    // completes it; the strobe shows one cycle later and is counted when it ends.
    logic        m_ready, m_pend, m_par, m_done, m_err;
    logic [15:0] m_addr, m_cnt, m_en;
    logic [31:0] m_data;
    logic        m_xfer, m_ok, m_end_now;
    logic [1:0]  m_op;

    assign m_xfer    = cfg_in_valid && m_ready;
    assign m_op      = cfg_in_data[31:30];
    assign m_end_now = m_xfer && !m_pend && m_op == 2'b10;
`ifdef CFG_STREAM_LOADER_PARITY_EN
    assign m_ok = (m_addr < 16) && (m_par == ^cfg_in_data);
`else
    assign m_ok = (m_addr < 16);
`endif

    always @(posedge clk) begin
        if (reset) begin
            m_ready <= 1'b0;
            m_pend  <= 1'b0;
            m_par   <= 1'b0;
            m_done  <= 1'b0;
            m_err   <= 1'b0;
            m_addr  <= '0;
            m_cnt   <= '0;
            m_en    <= '0;
            m_data  <= '0;
        end else begin
            m_en <= '0;
            if (m_en != 0 && m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
            if (m_xfer && m_pend) begin
                m_data <= cfg_in_data;
                m_pend <= 1'b0;
                if (m_ok) m_en <= 16'd1 << m_addr;
                else m_err <= 1'b1;
            end else if (m_xfer) begin
                if (m_op == 2'b01) begin
                    m_pend <= 1'b1;
                    m_addr <= cfg_in_data[15:0];
                    m_par  <= cfg_in_data[29];
                end else if (m_op == 2'b10) begin
                    m_done <= 1'b1;
                end else begin
                    m_err <= 1'b1;
                end
            end
            m_ready <= !(m_done || m_end_now) && !(m_xfer && m_pend);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("ready", {31'd0, cfg_in_ready}, {31'd0, m_ready});
            chk("en", {16'd0, config_en}, {16'd0, m_en});
            chk("data", config_data, m_data);
            chk("done", {31'd0, config_done}, {31'd0, m_done});
            chk("error", {31'd0, config_error}, {31'd0, m_err});
            chk("count", {16'd0, write_count}, {16'd0, m_cnt});
        end
    end

    // Present a word and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] w);
        bit taken = 1'b0;
        @(negedge clk);
        cfg_in_valid = 1'b1;
        cfg_in_data  = w;
        for (int i = 0; i < 20 && !taken; i++) begin
            if (cfg_in_ready) begin
                @(posedge clk);
                taken = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!taken) chk("send_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        cfg_in_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, cfg_in_ready}, 32'd0);
        chk("rst_en", {16'd0, config_en}, 32'd0);
        chk("rst_data", config_data, 32'd0);
        chk("rst_flags", {30'd0, config_done, config_error}, 32'd0);
        chk("rst_count", {16'd0, write_count}, 32'd0);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] gen();
        int unsigned r = $urandom_range(0, 99);
        logic        b = 1'($urandom_range(0, 1));
        if (r < 70) return {2'b01, b, 13'($urandom), 16'($urandom_range(0, 19))};
        else if (r < 73) return {2'b10, 30'($urandom)};
        else if (r < 83) return {b, b, 30'($urandom)};
        else return $urandom;
    endfunction

    initial begin
        reset        = 1'b1;
        cfg_in_valid = 1'b0;
        cfg_in_data  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_on = 1'b1;
        reset  = 1'b0;

        // Basic write, valid held high.
        send(32'h4000_0003);
        send(32'hDEAD_BEEF);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t1_en", {16'd0, config_en}, 32'h0000_0008);
        chk("t1_data", config_data, 32'hDEAD_BEEF);
        chk("t1_ready", {31'd0, cfg_in_ready}, 32'd0);
        @(negedge clk);
        chk("t1_en_off", {16'd0, config_en}, 32'd0);
        chk("t1_ready_back", {31'd0, cfg_in_ready}, 32'd1);
        chk("t1_count", {16'd0, write_count}, 32'd1);

        // Out-of-range address.
        do_reset();
        send(32'h4000_0020);
        send(32'h0000_0001);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t2_en", {16'd0, config_en}, 32'd0);
        chk("t2_err", {31'd0, config_error}, 32'd1);
        @(negedge clk);
        chk("t2_count", {16'd0, write_count}, 32'd0);
        chk("t2_ready", {31'd0, cfg_in_ready}, 32'd1);

        // Illegal opcode, then a good write to tile 0.
        do_reset();
        send(32'hC000_0000);
        send(32'h4000_0000);
        send(32'h1234_5678);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t3_err", {31'd0, config_error}, 32'd1);
        chk("t3_en", {16'd0, config_en}, 32'h0000_0001);

        // END header: no further words accepted.
        send(32'h8000_0000);
        @(negedge clk);
        chk("t4_done", {31'd0, config_done}, 32'd1);
        cfg_in_data = 32'h4000_0001;
        repeat (5) begin
            @(negedge clk);
            chk("t4_ready", {31'd0, cfg_in_ready}, 32'd0);
            chk("t4_en", {16'd0, config_en}, 32'd0);
        end
        do_reset();

        // Reset between header and data discards the pending pair.
        send(32'h4000_0005);
        do_reset();
        send(32'h0000_1234);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t5_err", {31'd0, config_error}, 32'd1);
        chk("t5_en", {16'd0, config_en}, 32'd0);

        do_reset();
`ifdef CFG_STREAM_LOADER_PARITY_EN
        send(32'h6000_0002);
        send(32'h0000_0003);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t6_par_en", {16'd0, config_en}, 32'd0);
        chk("t6_par_err", {31'd0, config_error}, 32'd1);
        do_reset();
        send(32'h4000_0002);
        send(32'h0000_0003);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t6_ok_en", {16'd0, config_en}, 32'h0000_0004);
`else
        send(32'h6000_0002);
        send(32'h0000_0003);
        @(negedge clk);
        cfg_in_valid = 1'b0;
        chk("t6_nopar_en", {16'd0, config_en}, 32'h0000_0004);
        chk("t6_nopar_err", {31'd0, config_error}, 32'd0);
`endif

        // Random stream with occasional resets and idle cycles.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            reset        = ($urandom_range(0, 149) == 0);
            cfg_in_valid = ($urandom_range(0, 3) != 0);
            cfg_in_data  = gen();
        end
        @(negedge clk);
        reset        = 1'b0;
        cfg_in_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cfg_stream_loader.md
Name: cfg_stream_loader

Overview:
- Configuration distribution stage directly upstream of the tile switch boxes and PE config registers.
- Accepts a 32-bit word stream over a valid/ready handshake and parses (header, data) pairs.
- Drives a shared 32-bit config_data bus plus a one-hot, single-cycle config_en per tile, so exactly one tile latches each data word.
- Signals end-of-bitstream and sticky protocol errors.

Parameters:
- NUM_TILES, 16: number of config_en outputs. Legal range 1..65536.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cfg_in_valid  in  1  upstream word valid.
- cfg_in_ready  out  1  loader can accept a word this cycle.
- cfg_in_data  in  32  stream word, either header or data.
- config_data  out  32  registered data word, broadcast to all tiles.
- config_en  out  NUM_TILES  one-hot write strobe; bit i targets tile i.
- config_done  out  1  sticky; END header has been received.
- config_error  out  1  sticky; protocol, address or parity error seen.
- write_count  out  16  number of completed tile writes; saturates at 16'hFFFF.

Behaviour:
- Reset clocks clk, synchronous, active-high. All outputs reset to 0 (config_en all zero); state returns to HEADER.
- Transfer rule: a word transfers when cfg_in_valid && cfg_in_ready. cfg_in_ready is a registered function of state.
- Header format:
  - [31:30] opcode: 2'b01 WRITE, 2'b10 END, other values illegal.
  - [29] parity bit; used only with the optional feature.
  - [15:0] tile address.
  - [28:16] ignored.
- States: HEADER, DATA, WRITE, DONE.
- HEADER (ready=1):
  - WRITE opcode: latch address, go to DATA.
  - END opcode: set config_done, go to DONE.
  - Illegal opcode: set config_error, stay in HEADER; the word is consumed.
- DATA (ready=1): on transfer, config_data <= word and go to WRITE.
  - If latched address < NUM_TILES: config_en <= one-hot(address).
  - Otherwise: config_en stays 0 and config_error is set.
- WRITE (ready=0), exactly one cycle:
  - config_en high for this cycle only; cleared on exit.
  - write_count increments if the strobe was issued.
  - Returns to HEADER.
- DONE (ready=0): held until reset. config_data holds its last value. config_en stays 0.
- Latency: data word accepted in cycle t -> config_data and config_en valid in cycle t+1 -> tile register updates at the t+2 edge.
- Throughput: at most one tile write per 3 cycles. Valid may be low for any number of cycles in any state; the FSM simply waits.
- config_data only changes on a DATA transfer. Between writes it holds its value, so tiles that sample late still see stable data.
- Back-to-back writes to the same address are legal; each issues its own strobe.
- write_count saturates at 16'hFFFF: no wrap, no error.
- Reset asserted mid-operation (any state, including WRITE): the next cycle is HEADER with config_en=0. A partially received pair is discarded and no strobe is issued.

Optional Feature:
- Macro: CFG_STREAM_LOADER_PARITY_EN.
- Defined: header[29] must equal the XOR of all 32 bits of the following data word.
  - On mismatch: config_en stays 0, config_error is set, write_count unchanged.
  - The data word is still consumed and the WRITE cycle still occurs, so timing is identical.
- Undefined: header[29] is ignored and no parity logic is built.

Decomposition:
- Shared package cfg_stream_pkg:
  - Opcode constants OP_WRITE=2'b01 and OP_END=2'b10.
  - Field position constants: opcode [31:30], parity bit 29, address [15:0].
  - State enum.
  - Config word width constant 32, shared with the switch-box config register width.
- One sub-module: cfg_addr_decoder.
  - 16-bit address in -> NUM_TILES one-hot out, plus an in_range flag.
  - Purely combinational; the registered strobe stays in the parent.

Test Plan:
- Reset then stream 0x4000_0003, 0xDEAD_BEEF with valid held high:
  - config_en == 16'h0008 for exactly one cycle, config_data == 0xDEADBEEF, write_count == 1.
  - cfg_in_ready low for exactly that cycle.
- Header 0x4000_0020 (address 32 >= 16), then data 0x1:
  - no config_en bit ever set, config_error == 1, write_count == 0, FSM back in HEADER.
- Header 0xC000_0000 (illegal opcode), then a valid pair to address 0:
  - config_error == 1; the following write still lands with config_en == 16'h0001.
- Header 0x8000_0000:
  - config_done == 1 and cfg_in_ready == 0 thereafter; further valid words are ignored.
  - After reset, all outputs are 0.
- Header to address 5, pulse reset one cycle, then data 0x1234:
  - 0x1234 is treated as a header (opcode 00, illegal) -> config_error == 1, no strobe.
- With CFG_STREAM_LOADER_PARITY_EN, send header 0x6000_0002 (parity 1) with data 0x0000_0003 (XOR 0):
  - no strobe, config_error == 1.
  - Repeating with header 0x4000_0002 gives config_en == 16'h0004.
